// File: rtl/pipeline_controller.sv
//------------------------------------------------------------------------------
// Module  : pipeline_controller
// Brief   : Hazard, multi-cycle divide and flush control for a 5-stage pipeline.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipeline_controller #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_uses_rs,
  input  logic        ID_uses_rt,
  input  logic        EX_Memory_read,
  input  logic [4:0]  EX_Write_back_address,
  input  logic        Div_start,
  input  logic        Branch_taken,
  input  logic        Exception,
  output logic        PC_write,
  output logic        IF_ID_write,
  output logic        ID_EX_write,
  output logic        ID_EX_bubble,
  output logic        Flush,
  output logic        Div_done,
  output logic        Busy,
  output logic [15:0] Stall_count
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_DIV_WAIT = 2'd1,
    S_FLUSH    = 2'd2
  } state_t;

  localparam logic [5:0] c_DIV_LOAD = 6'(DIV_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [5:0]  r_div_cnt;
  logic [5:0]  w_div_cnt_next;
  logic [15:0] r_stall_count;
  logic        w_hazard;

  assign w_hazard = EX_Memory_read && (EX_Write_back_address != 5'd0) &&
                    ((ID_uses_rs && (ID_rs == EX_Write_back_address)) ||
                     (ID_uses_rt && (ID_rt == EX_Write_back_address)));

  assign Stall_count = r_stall_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_RUN;
      r_div_cnt     <= 6'd0;
      r_stall_count <= 16'd0;
    end else begin
      r_state   <= w_state_next;
      r_div_cnt <= w_div_cnt_next;
      if (!PC_write && (r_stall_count != 16'hFFFF)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_div_cnt_next = r_div_cnt;
    PC_write       = 1'b1;
    IF_ID_write    = 1'b1;
    ID_EX_write    = 1'b1;
    ID_EX_bubble   = 1'b0;
    Flush          = 1'b0;
    Div_done       = 1'b0;
    Busy           = 1'b0;

    case (r_state)
      S_RUN: begin
        if (Exception) begin
          Flush        = 1'b1;
          w_state_next = S_FLUSH;
        end else if (Branch_taken) begin
          Flush = 1'b1;
        end else if (Div_start) begin
          w_state_next   = S_DIV_WAIT;
          w_div_cnt_next = c_DIV_LOAD;
        end else if (w_hazard) begin
          PC_write     = 1'b0;
          IF_ID_write  = 1'b0;
          ID_EX_bubble = 1'b1;
        end
      end
      S_DIV_WAIT: begin
        PC_write    = 1'b0;
        IF_ID_write = 1'b0;
        ID_EX_write = 1'b0;
        Busy        = 1'b1;
        // An exception aborts the divide before the done pulse can fire.
        if (Exception) begin
          Flush          = 1'b1;
          w_div_cnt_next = 6'd0;
          w_state_next   = S_FLUSH;
        end else if (r_div_cnt == 6'd0) begin
          Div_done     = 1'b1;
          w_state_next = S_RUN;
        end else begin
          w_div_cnt_next = r_div_cnt - 6'd1;
        end
      end
      S_FLUSH: begin
        Flush        = 1'b1;
        Busy         = 1'b1;
        w_state_next = S_RUN;
      end
      default: begin
        w_state_next = S_RUN;
      end
    endcase

    // Reset presents a quiet pipeline regardless of state or inputs.
    if (reset) begin
      PC_write     = 1'b1;
      IF_ID_write  = 1'b1;
      ID_EX_write  = 1'b1;
      ID_EX_bubble = 1'b0;
      Flush        = 1'b0;
      Div_done     = 1'b0;
      Busy         = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_controller.sv
//------------------------------------------------------------------------------
// Module  : tb_pipeline_controller
// Brief   : Scoreboard bench for pipeline_controller with directed vectors.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  ID_rs, ID_rt, EX_Write_back_address;
  logic        ID_uses_rs, ID_uses_rt, EX_Memory_read;
  logic        Div_start, Branch_taken, Exception;
  logic        PC_write, IF_ID_write, ID_EX_write, ID_EX_bubble;
  logic        Flush, Div_done, Busy;
  logic [15:0] Stall_count;

  pipeline_controller #(.DIV_CYCLES(32)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .ID_rs                 (ID_rs),
    .ID_rt                 (ID_rt),
    .ID_uses_rs            (ID_uses_rs),
    .ID_uses_rt            (ID_uses_rt),
    .EX_Memory_read        (EX_Memory_read),
    .EX_Write_back_address (EX_Write_back_address),
    .Div_start             (Div_start),
    .Branch_taken          (Branch_taken),
    .Exception             (Exception),
    .PC_write              (PC_write),
    .IF_ID_write           (IF_ID_write),
    .ID_EX_write           (ID_EX_write),
    .ID_EX_bubble          (ID_EX_bubble),
    .Flush                 (Flush),
    .Div_done              (Div_done),
    .Busy                  (Busy),
    .Stall_count           (Stall_count)
  );

  always #5 clock = ~clock;

  // Fields: pcw, ifw, idw, bubble, flush, div_done, busy, stall_count
  typedef struct packed {
    logic        pcw;
    logic        ifw;
    logic        idw;
    logic        bub;
    logic        fl;
    logic        dd;
    logic        busy;
    logic [15:0] sc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    total  = 0;
  int    passed = 0;

  function automatic exp_t mk(input logic pcw, ifw, idw, bub, fl, dd, busy,
                              input logic [15:0] sc);
    mk = '{pcw, ifw, idw, bub, fl, dd, busy, sc};
  endfunction

  function automatic exp_t dflt(input logic [15:0] sc);
    dflt = mk(1, 1, 1, 0, 0, 0, 0, sc);
  endfunction

  function automatic exp_t stall(input logic [15:0] sc);
    stall = mk(0, 0, 1, 1, 0, 0, 0, sc);
  endfunction

  function automatic exp_t divw(input logic dd, input logic [15:0] sc);
    divw = mk(0, 0, 0, 0, 0, dd, 1, sc);
  endfunction

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    reset = 0; ID_rs = 0; ID_rt = 0; ID_uses_rs = 0; ID_uses_rt = 0;
    EX_Memory_read = 0; EX_Write_back_address = 0;
    Div_start = 0; Branch_taken = 0; Exception = 0;
  endtask

  task automatic hazard_rt(input logic [4:0] addr);
    EX_Memory_read = 1; EX_Write_back_address = addr; ID_rt = addr; ID_uses_rt = 1;
  endtask

  task automatic expect_out(input string nm, input exp_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compare the DUT outputs for the current cycle mid-cycle.
  initial begin
    exp_t  e;
    exp_t  act;
    string nm;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        act = '{PC_write, IF_ID_write, ID_EX_write, ID_EX_bubble,
                Flush, Div_done, Busy, Stall_count};
        total++;
        if (act === e) passed++;
        else $display("FAIL %s: got pcw%b ifw%b idw%b bub%b fl%b dd%b busy%b sc=%h, want pcw%b ifw%b idw%b bub%b fl%b dd%b busy%b sc=%h",
                      nm, act.pcw, act.ifw, act.idw, act.bub, act.fl, act.dd, act.busy, act.sc,
                      e.pcw, e.ifw, e.idw, e.bub, e.fl, e.dd, e.busy, e.sc);
      end
    end
  end

  initial begin
    idle();
    reset = 1;
    next_cycle();
    // Reset with every hazard/event input active still shows quiet outputs.
    reset = 1; Exception = 1; Branch_taken = 1; Div_start = 1; hazard_rt(5'd5);
    expect_out("reset_quiet", dflt(16'd0));
    next_cycle(); idle();
    expect_out("idle_after_reset", dflt(16'd0));

    next_cycle(); idle(); hazard_rt(5'd5);
    expect_out("loaduse_rt5", stall(16'd0));
    next_cycle(); idle();
    expect_out("after_loaduse", dflt(16'd1));
    next_cycle(); idle(); hazard_rt(5'd0);
    expect_out("addr0_no_stall", dflt(16'd1));
    next_cycle(); idle();
    EX_Memory_read = 1; EX_Write_back_address = 5'd7; ID_rs = 5'd7; ID_uses_rs = 0;
    expect_out("rs_unused_no_stall", dflt(16'd1));
    next_cycle(); ID_uses_rs = 1;
    expect_out("loaduse_rs7", stall(16'd1));
    next_cycle(); idle(); hazard_rt(5'd9); Branch_taken = 1;
    expect_out("branch_over_hazard", mk(1, 1, 1, 0, 1, 0, 0, 16'd2));
    next_cycle(); idle(); hazard_rt(5'd9); Div_start = 1; Exception = 1;
    expect_out("exception_run", mk(1, 1, 1, 0, 1, 0, 0, 16'd2));
    next_cycle(); idle(); Exception = 1;
    expect_out("flush_state", mk(1, 1, 1, 0, 1, 0, 1, 16'd2));
    next_cycle(); idle();
    expect_out("run_after_flush", dflt(16'd2));

    // Full divide: 32 stalled cycles, done on the last, events ignored.
    next_cycle(); idle(); Div_start = 1;
    expect_out("div_start", dflt(16'd2));
    for (int k = 0; k < 32; k++) begin
      next_cycle(); idle();
      if (k == 5) Branch_taken = 1;
      if (k == 6) hazard_rt(5'd3);
      if (k == 7) Div_start = 1;
      expect_out($sformatf("div_wait_%0d", k), divw(k == 31, 16'(2 + k)));
    end
    next_cycle(); idle();
    expect_out("run_after_div", dflt(16'd34));

    // Exception on the 10th stalled cycle of a divide.
    next_cycle(); idle(); Div_start = 1;
    expect_out("div2_start", dflt(16'd34));
    for (int k = 0; k < 9; k++) begin
      next_cycle(); idle();
      expect_out($sformatf("div2_wait_%0d", k), divw(1'b0, 16'(34 + k)));
    end
    next_cycle(); idle(); Exception = 1;
    expect_out("div2_abort", mk(0, 0, 0, 0, 1, 0, 1, 16'd43));
    next_cycle(); idle();
    expect_out("div2_flush", mk(1, 1, 1, 0, 1, 0, 1, 16'd44));
    next_cycle(); idle();
    expect_out("div2_run", dflt(16'd44));

    // Reset in the middle of a divide.
    next_cycle(); idle(); Div_start = 1;
    expect_out("div3_start", dflt(16'd44));
    for (int k = 0; k < 3; k++) begin
      next_cycle(); idle();
      expect_out($sformatf("div3_wait_%0d", k), divw(1'b0, 16'(44 + k)));
    end
    next_cycle(); idle(); reset = 1;
    expect_out("div3_reset", dflt(16'd47));
    next_cycle(); idle();
    expect_out("div3_after_reset", dflt(16'd0));

    // Saturation of the stall counter.
    next_cycle(); idle(); hazard_rt(5'd12);
    expect_out("sat_first", stall(16'd0));
    for (int k = 0; k < 70000; k++) next_cycle();
    idle();
    expect_out("sat_hold", dflt(16'hFFFF));
    next_cycle(); hazard_rt(5'd12);
    expect_out("sat_extra_stall", stall(16'hFFFF));
    next_cycle(); idle();
    expect_out("sat_still", dflt(16'hFFFF));

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clock);
    if (exp_q.size() > 0) begin
      total++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
